// File: rtl/synth_pkg.sv
// Shared helpers for poly_square_synth: width arithmetic and output clamping.
package synth_pkg;

    // Ceiling log2; returns 0 for an argument of 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Width of the signed voice sum; wide enough that no voice mix can overflow.
    function automatic int sum_width(input int amp_w, input int voices);
        return amp_w + clog2(voices) + 1;
    endfunction

    // Left shift that moves an AMP_W magnitude up to full sample scale.
    function automatic int shift_width(input int sample_w, input int amp_w);
        return sample_w - 1 - amp_w;
    endfunction

    // Clamp a signed value into the range of a signed integer of the given width.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input int                 width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/square_voice.sv
// One square-wave voice: shadowed period/duty/amp, phase counter, registered
// square bit and the signed contribution it makes to the mix.
module square_voice
    import synth_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int AMP_W    = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_load,
    input  logic                voice_en,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic [PERIOD_W-1:0] duty_in,
    input  logic [AMP_W-1:0]    amp_in,
    output logic                voice_out,
    output logic signed [AMP_W:0] contrib
);

    localparam logic [PERIOD_W-1:0] PER_MIN = PERIOD_W'(2);
    localparam logic [PERIOD_W-1:0] ONE     = PERIOD_W'(1);

    logic [PERIOD_W-1:0] per_q, per_d;
    logic [PERIOD_W-1:0] duty_q, duty_d;
    logic [AMP_W-1:0]    amp_q, amp_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                voice_out_q, voice_out_d;
    logic                active;
    logic signed [AMP_W:0] amp_s;

    // Next-state for shadow registers, phase counter and square bit.
    always_comb begin
        per_d       = per_q;
        duty_d      = duty_q;
        amp_d       = amp_q;
        cnt_d       = cnt_q;
        voice_out_d = 1'b0;
        active      = voice_en && (per_q >= PER_MIN);

        if (active) begin
            voice_out_d = (cnt_q < duty_q);
            if (cnt_q >= per_q - ONE) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end else begin
            cnt_d = '0;
        end

        // A new configuration restarts every voice at phase 0 together.
        if (cfg_load) begin
            per_d  = period_in;
            duty_d = duty_in;
            amp_d  = amp_in;
            cnt_d  = '0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            per_q       <= '0;
            duty_q      <= '0;
            amp_q       <= '0;
            cnt_q       <= '0;
            voice_out_q <= 1'b0;
        end else begin
            per_q       <= per_d;
            duty_q      <= duty_d;
            amp_q       <= amp_d;
            cnt_q       <= cnt_d;
            voice_out_q <= voice_out_d;
        end
    end

    // Signed contribution; enable is applied live so a muted voice drops out at once.
    always_comb begin
        amp_s   = signed'({1'b0, amp_q});
        contrib = '0;
        if (active) begin
            contrib = voice_out_q ? amp_s : -amp_s;
        end
    end

    assign voice_out = voice_out_q;

endmodule

// File: rtl/poly_square_synth.sv
// N-voice square-wave synthesiser with mixer and a 1-entry valid/ready output.
// Build option SYNTH_SATURATE_EN: full-scale sum with clamping and sticky clip;
// when undefined the mix is the voice mean (cannot overflow) and clip stays 0.
module poly_square_synth
    import synth_pkg::*;
#(
    parameter int VOICES   = 4,
    parameter int PERIOD_W = 16,
    parameter int AMP_W    = 12,
    parameter int SAMPLE_W = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cfg_load,
    input  logic [VOICES-1:0]            voice_en,
    input  logic [VOICES*PERIOD_W-1:0]   period,
    input  logic [VOICES*PERIOD_W-1:0]   duty,
    input  logic [VOICES*AMP_W-1:0]      amp,
    output logic [VOICES-1:0]            voice_out,
    output logic signed [SAMPLE_W-1:0]   sample,
    output logic                         sample_valid,
    input  logic                         sample_ready,
    output logic                         clip
);

    localparam int SUM_W = sum_width(AMP_W, VOICES);
    localparam int SHIFT = shift_width(SAMPLE_W, AMP_W);

    logic signed [AMP_W:0]    contrib [VOICES];
    logic signed [SUM_W-1:0]  sum;
    logic signed [SAMPLE_W-1:0] mix;
    logic                     clamp;
    logic                     load;

    logic signed [SAMPLE_W-1:0] sample_q, sample_d;
    logic                     valid_q, valid_d;
    logic                     clip_q, clip_d;

    for (genvar gi = 0; gi < VOICES; gi++) begin : g_voice
        square_voice #(
            .PERIOD_W (PERIOD_W),
            .AMP_W    (AMP_W)
        ) u_voice (
            .clk       (clk),
            .reset     (reset),
            .cfg_load  (cfg_load),
            .voice_en  (voice_en[gi]),
            .period_in (period[gi*PERIOD_W +: PERIOD_W]),
            .duty_in   (duty[gi*PERIOD_W +: PERIOD_W]),
            .amp_in    (amp[gi*AMP_W +: AMP_W]),
            .voice_out (voice_out[gi]),
            .contrib   (contrib[gi])
        );
    end

    // Sum of all voice contributions.
    always_comb begin
        sum = '0;
        for (int i = 0; i < VOICES; i++) begin
            sum = sum + SUM_W'(contrib[i]);
        end
    end

`ifdef SYNTH_SATURATE_EN
    logic signed [63:0] wide;
    logic signed [63:0] sat_v;

    // Scale the raw sum to full range and clamp into the sample width.
    always_comb begin
        wide  = 64'(sum) <<< SHIFT;
        sat_v = saturate(wide, SAMPLE_W);
        mix   = sat_v[SAMPLE_W-1:0];
        clamp = (sat_v != wide);
    end
`else
    localparam int CLOG_V = clog2(VOICES);
    logic signed [SUM_W-1:0] mean;

    // Average the voices, then scale; the mean always fits in the sample.
    always_comb begin
        mean  = sum >>> CLOG_V;
        mix   = SAMPLE_W'(mean) <<< SHIFT;
        clamp = 1'b0;
    end
`endif

    // Output register next-state: refill when empty or when the consumer takes it.
    always_comb begin
        load     = !valid_q || sample_ready;
        sample_d = load ? mix : sample_q;
        valid_d  = 1'b1;
        clip_d   = clip_q;
        if (cfg_load) begin
            clip_d = 1'b0;
        end
        if (load && clamp) begin
            clip_d = 1'b1;
        end
    end

    // Output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sample_q <= '0;
            valid_q  <= 1'b0;
            clip_q   <= 1'b0;
        end else begin
            sample_q <= sample_d;
            valid_q  <= valid_d;
            clip_q   <= clip_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign clip         = clip_q;

endmodule

// File: tb/tb_poly_square_synth.sv
// Directed self-checking bench for poly_square_synth (VOICES=4, PERIOD_W=16,
// AMP_W=12, SAMPLE_W=16). Expected values follow SYNTH_SATURATE_EN.
module tb_poly_square_synth;

`ifdef SYNTH_SATURATE_EN
    localparam int A1K     = 8000;
    localparam int FULL_HI = 32767;
    localparam int FULL_LO = -32768;
    localparam bit CLIP_EXP = 1'b1;
`else
    localparam int A1K     = 2000;
    localparam int FULL_HI = 32760;
    localparam int FULL_LO = -32760;
    localparam bit CLIP_EXP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               cfg_load;
    logic [3:0]         voice_en;
    logic [63:0]        period;
    logic [63:0]        duty;
    logic [47:0]        amp;
    logic [3:0]         voice_out;
    logic signed [15:0] sample;
    logic               sample_valid;
    logic               sample_ready;
    logic               clip;

    int n_cmp = 0;
    int n_bad = 0;

    poly_square_synth #(
        .VOICES   (4),
        .PERIOD_W (16),
        .AMP_W    (12),
        .SAMPLE_W (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_load     (cfg_load),
        .voice_en     (voice_en),
        .period       (period),
        .duty         (duty),
        .amp          (amp),
        .voice_out    (voice_out),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .clip         (clip)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_voice(input int i, input int per, input int dt, input int a);
        period[i*16 +: 16] = 16'(per);
        duty[i*16 +: 16]   = 16'(dt);
        amp[i*12 +: 12]    = 12'(a);
    endtask

    // quiet=1 mutes the voices during the load cycle so voice_out starts at 0.
    task automatic pulse_cfg(input bit quiet);
        logic [3:0] saved;
        saved = voice_en;
        if (quiet) voice_en = 4'b0000;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        voice_en = saved;
    endtask

    // Square bit after the k-th edge following an aligned load, per=8 duty=4.
    function automatic bit exp_vo(input int k);
        return (k >= 1) && (((k - 1) % 8) < 4);
    endfunction

    task automatic test_reset();
        reset        = 1'b0;
        cfg_load     = 1'b1;
        voice_en     = 4'hF;
        sample_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_voice(i, 8, 4, 4095);
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (voice_out !== 4'b0000) begin n_bad++; $display("FAIL reset_voice_out: got %b expected 0000", voice_out); end
            n_cmp++; if (sample !== 16'sd0) begin n_bad++; $display("FAIL reset_sample: got %0d expected 0", sample); end
            n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", sample_valid); end
            n_cmp++; if (clip !== 1'b0) begin n_bad++; $display("FAIL reset_clip: got %b expected 0", clip); end
        end
        cfg_load = 1'b0;
        voice_en = 4'h0;
        reset    = 1'b1;
        tick();
        n_cmp++; if (sample_valid !== 1'b1) begin n_bad++; $display("FAIL release_valid: got %b expected 1", sample_valid); end
        n_cmp++; if (sample !== 16'sd0) begin n_bad++; $display("FAIL release_sample: got %0d expected 0", sample); end
    endtask

    task automatic test_voice0_wave();
        set_voice(0, 8, 4, 1000);
        for (int i = 1; i < 4; i++) set_voice(i, 0, 0, 0);
        voice_en = 4'b0001;
        pulse_cfg(1'b0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_cmp++;
            if (voice_out !== {3'b000, exp_vo(k)}) begin
                n_bad++; $display("FAIL wave_k%0d: got %b expected %b", k, voice_out, {3'b000, exp_vo(k)});
            end
        end
    endtask

    task automatic test_voice0_mix();
        int e;
        pulse_cfg(1'b1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            e = exp_vo(k - 1) ? A1K : -A1K;
            n_cmp++; if (sample !== 16'(e)) begin n_bad++; $display("FAIL mix1_k%0d: got %0d expected %0d", k, sample, e); end
            n_cmp++; if (sample_valid !== 1'b1) begin n_bad++; $display("FAIL mix1_valid_k%0d: got %b expected 1", k, sample_valid); end
        end
    endtask

    task automatic test_all_voices();
        int e;
        for (int i = 0; i < 4; i++) set_voice(i, 8, 4, 4095);
        voice_en = 4'hF;
        pulse_cfg(1'b1);
        n_cmp++; if (clip !== 1'b0) begin n_bad++; $display("FAIL all_clip_start: got %b expected 0", clip); end
        for (int k = 1; k <= 16; k++) begin
            tick();
            e = exp_vo(k - 1) ? FULL_HI : FULL_LO;
            n_cmp++; if (sample !== 16'(e)) begin n_bad++; $display("FAIL all_k%0d: got %0d expected %0d", k, sample, e); end
            n_cmp++; if (clip !== CLIP_EXP) begin n_bad++; $display("FAIL all_clip_k%0d: got %b expected %b", k, clip, CLIP_EXP); end
        end
        pulse_cfg(1'b0);
        n_cmp++; if (clip !== CLIP_EXP) begin n_bad++; $display("FAIL clip_set_wins: got %b expected %b", clip, CLIP_EXP); end
        pulse_cfg(1'b1);
        n_cmp++; if (clip !== 1'b0) begin n_bad++; $display("FAIL clip_cleared: got %b expected 0", clip); end
    endtask

    task automatic test_edge_cases();
        for (int i = 1; i < 4; i++) set_voice(i, 0, 0, 0);
        voice_en = 4'b0001;
        set_voice(0, 1, 1, 1000);
        pulse_cfg(1'b1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_cmp++; if (voice_out !== 4'b0000) begin n_bad++; $display("FAIL per1_vo_k%0d: got %b expected 0000", k, voice_out); end
            n_cmp++; if (sample !== 16'sd0) begin n_bad++; $display("FAIL per1_sample_k%0d: got %0d expected 0", k, sample); end
        end
        set_voice(0, 8, 9, 1000);
        pulse_cfg(1'b1);
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_cmp++; if (voice_out !== 4'b0001) begin n_bad++; $display("FAIL duty_ge_per_k%0d: got %b expected 0001", k, voice_out); end
            if (k >= 2) begin
                n_cmp++; if (sample !== 16'(A1K)) begin n_bad++; $display("FAIL duty_ge_per_sample_k%0d: got %0d expected %0d", k, sample, A1K); end
            end
        end
        set_voice(0, 8, 4, 1000);
        pulse_cfg(1'b1);
        for (int c = 0; c < 6; c++) tick();
        pulse_cfg(1'b0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_cmp++;
            if (voice_out !== {3'b000, exp_vo(k)}) begin
                n_bad++; $display("FAIL restart_k%0d: got %b expected %b", k, voice_out, {3'b000, exp_vo(k)});
            end
        end
    endtask

    task automatic test_backpressure();
        for (int i = 1; i < 4; i++) set_voice(i, 0, 0, 0);
        set_voice(0, 8, 4, 1000);
        voice_en     = 4'b0001;
        sample_ready = 1'b1;
        pulse_cfg(1'b1);
        tick();
        n_cmp++; if (sample !== 16'(-A1K)) begin n_bad++; $display("FAIL bp_first: got %0d expected %0d", sample, -A1K); end
        sample_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++; if (sample !== 16'(-A1K)) begin n_bad++; $display("FAIL bp_hold_c%0d: got %0d expected %0d", c, sample, -A1K); end
            n_cmp++; if (sample_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_c%0d: got %b expected 1", c, sample_valid); end
        end
        sample_ready = 1'b1;
        tick();
        n_cmp++; if (sample !== 16'(A1K)) begin n_bad++; $display("FAIL bp_release: got %0d expected %0d", sample, A1K); end
        n_cmp++; if (voice_out !== 4'b0001) begin n_bad++; $display("FAIL bp_vo_before_reset: got %b expected 0001", voice_out); end
        reset = 1'b0;
        tick();
        n_cmp++; if (voice_out !== 4'b0000) begin n_bad++; $display("FAIL midreset_vo: got %b expected 0000", voice_out); end
        n_cmp++; if (sample !== 16'sd0) begin n_bad++; $display("FAIL midreset_sample: got %0d expected 0", sample); end
        n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_valid: got %b expected 0", sample_valid); end
        n_cmp++; if (clip !== 1'b0) begin n_bad++; $display("FAIL midreset_clip: got %b expected 0", clip); end
        reset = 1'b1;
        tick();
        n_cmp++; if (sample_valid !== 1'b1) begin n_bad++; $display("FAIL midreset_release_valid: got %b expected 1", sample_valid); end
    endtask

    initial begin
        reset        = 1'b0;
        cfg_load     = 1'b0;
        voice_en     = '0;
        period       = '0;
        duty         = '0;
        amp          = '0;
        sample_ready = 1'b1;
        test_reset();
        test_voice0_wave();
        test_voice0_mix();
        test_all_voices();
        test_edge_cases();
        test_backpressure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
